// File: rtl/isa_pkg.sv
// Shared ISA constants for the control-flow path: field widths, jump/call opcodes
// and the flag-condition evaluator used by the jump decoder.
package isa_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 15;
    localparam int OP_W    = 7;

    localparam logic [OP_W-1:0] OP_JMP  = 7'h4D;
    localparam logic [OP_W-1:0] OP_JEQ  = 7'h4E;
    localparam logic [OP_W-1:0] OP_JNE  = 7'h4F;
    localparam logic [OP_W-1:0] OP_JGT  = 7'h50;
    localparam logic [OP_W-1:0] OP_JLT  = 7'h51;
    localparam logic [OP_W-1:0] OP_JGE  = 7'h52;
    localparam logic [OP_W-1:0] OP_JLE  = 7'h53;
    localparam logic [OP_W-1:0] OP_JCR  = 7'h54;
    localparam logic [OP_W-1:0] OP_JOV  = 7'h55;
    localparam logic [OP_W-1:0] OP_CALL = 7'h56;
    localparam logic [OP_W-1:0] OP_RET  = 7'h57;

    // Non-jump opcodes (including CALL/RET) report "not taken".
    function automatic logic jump_taken(
        input logic [OP_W-1:0] op,
        input logic            z,
        input logic            n,
        input logic            c,
        input logic            v
    );
        logic taken_s;
        case (op)
            OP_JMP:  taken_s = 1'b1;
            OP_JEQ:  taken_s = z;
            OP_JNE:  taken_s = ~z;
            OP_JGT:  taken_s = ~z & ~n;
            OP_JLT:  taken_s = n;
            OP_JGE:  taken_s = ~n;
            OP_JLE:  taken_s = z | n;
            OP_JCR:  taken_s = c;
            OP_JOV:  taken_s = v;
            default: taken_s = 1'b0;
        endcase
        return taken_s;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. The caller guarantees push and pop are never asserted
// together; push while full and pop while empty are ignored.
module ret_stack #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  top,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [CW-1:0] cnt_r;
    logic [PW-1:0] wr_idx_s;
    logic [PW-1:0] top_idx_s;

    assign full      = (cnt_r == CW'(DEPTH));
    assign empty     = (cnt_r == {CW{1'b0}});
    assign cnt       = cnt_r;
    assign wr_idx_s  = cnt_r[PW-1:0];
    assign top_idx_s = cnt_r[PW-1:0] - PW'(1);

    // Top-of-stack view, zero when nothing is stored.
    always_comb begin
        top = {W{1'b0}};
        if (!empty) begin
            top = mem_r[top_idx_s];
        end else begin
            top = {W{1'b0}};
        end
    end

    // Storage and occupancy update.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (push && !full) begin
            mem_r[wr_idx_s] <= din;
            cnt_r           <= cnt_r + CW'(1);
        end else if (pop && !empty) begin
            cnt_r <= cnt_r - CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/jump_ctrl.sv
// Control-flow unit in front of the PC: decodes jumps, CALL and RET in the same
// cycle as the fetched instruction and keeps the return-address stack.
module jump_ctrl #(
    parameter int INSTR_W     = 15,
    parameter int ADDR_W      = 8,
    parameter int PC_LAST     = 91,
    parameter int STACK_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            pc,
    input  logic [INSTR_W-1:0]           instr,
    input  logic                         flag_z,
    input  logic                         flag_n,
    input  logic                         flag_c,
    input  logic                         flag_v,
    output logic                         l,
    output logic [ADDR_W-1:0]            dataIM,
    output logic                         stk_err,
    output logic [$clog2(STACK_DEPTH):0] stk_cnt
);

    import isa_pkg::*;

    localparam int OPW = INSTR_W - ADDR_W;

    logic [OPW-1:0]    opcode_s;
    logic [ADDR_W-1:0] literal_s;
    logic [ADDR_W-1:0] ret_addr_s;
    logic [ADDR_W-1:0] stk_top_s;
    logic              stk_full_s;
    logic              stk_empty_s;
    logic              push_s;
    logic              pop_s;
    logic              err_evt_s;
    logic              stk_err_r;

    assign opcode_s  = instr[INSTR_W-1:ADDR_W];
    assign literal_s = instr[ADDR_W-1:0];

    // The return address follows the PC's own wrap rather than mod-2^ADDR_W.
    assign ret_addr_s = (pc == ADDR_W'(PC_LAST)) ? {ADDR_W{1'b0}} : (pc + ADDR_W'(1));

    // Same-cycle decode; reset suppresses the load and any stack traffic.
    always_comb begin
        l         = 1'b0;
        dataIM    = {ADDR_W{1'b0}};
        push_s    = 1'b0;
        pop_s     = 1'b0;
        err_evt_s = 1'b0;
        if (rst) begin
            l      = 1'b0;
            dataIM = {ADDR_W{1'b0}};
        end else begin
            case (opcode_s)
                OP_CALL: begin
                    if (!stk_full_s) begin
                        l      = 1'b1;
                        dataIM = literal_s;
                        push_s = 1'b1;
                    end else begin
                        err_evt_s = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!stk_empty_s) begin
                        l      = 1'b1;
                        dataIM = stk_top_s;
                        pop_s  = 1'b1;
                    end else begin
                        err_evt_s = 1'b1;
                    end
                end
                default: begin
                    if (jump_taken(opcode_s, flag_z, flag_n, flag_c, flag_v)) begin
                        l      = 1'b1;
                        dataIM = literal_s;
                    end else begin
                        l      = 1'b0;
                        dataIM = {ADDR_W{1'b0}};
                    end
                end
            endcase
        end
    end

    // Sticky stack error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stk_err_r <= 1'b0;
        end else if (err_evt_s) begin
            stk_err_r <= 1'b1;
        end else begin
            stk_err_r <= stk_err_r;
        end
    end

    assign stk_err = stk_err_r;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (ret_addr_s),
        .top   (stk_top_s),
        .cnt   (stk_cnt),
        .full  (stk_full_s),
        .empty (stk_empty_s)
    );

endmodule

// File: doc/jump_ctrl.md
Name: jump_ctrl

Overview:
- Control-flow unit that sits in front of the program counter.
- Each cycle it decodes the instruction currently addressed by `pc` (combinational instruction-memory output) together with the ALU status flags.
- It drives the PC load strobe `l` and load value `dataIM`.
- It holds a small return-address stack so that CALL/RET work alongside the PC's increment and wrap-at-PC_LAST behaviour.

Parameters:
- INSTR_W, 15, instruction width; opcode = instr[14:8], literal = instr[7:0]
- ADDR_W, 8, program address width
- PC_LAST, 91, last valid program address; the PC wraps to 0 after it
- STACK_DEPTH, 4, return-address stack entries (power of two)

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- pc  in  ADDR_W  current program counter
- instr  in  INSTR_W  instruction at `pc` (combinational ROM output)
- flag_z  in  1  zero flag from ALU status register
- flag_n  in  1  negative flag
- flag_c  in  1  carry flag
- flag_v  in  1  overflow flag
- l  out  1  PC load strobe; PC takes `dataIM` at the next posedge
- dataIM  out  ADDR_W  PC load value
- stk_err  out  1  sticky stack overflow/underflow error
- stk_cnt  out  $clog2(STACK_DEPTH)+1  current stack occupancy

Behaviour:
- `l` and `dataIM` are combinational from `instr`, the flags and the stack top.
  - This gives zero added latency: a jump at address A makes the PC hold the target on the cycle after A.
- While `rst`=1 the outputs are forced: l=0, dataIM=0.
- Reset state (next posedge): stack emptied (stk_cnt=0), stk_err=0, all stack entries=0.
- When `l`=0, dataIM=0.
- Jump decode (literal = instr[7:0]):
  - JMP: always taken.
  - JEQ: taken if Z.
  - JNE: taken if !Z.
  - JGT: taken if !Z & !N.
  - JLT: taken if N.
  - JGE: taken if !N.
  - JLE: taken if Z | N.
  - JCR: taken if C.
  - JOV: taken if V.
  - When taken: l=1, dataIM=literal.
  - When not taken: l=0.
- CALL:
  - If stk_cnt<STACK_DEPTH: l=1, dataIM=literal; at posedge push ret_addr and stk_cnt+=1.
  - ret_addr = (pc==PC_LAST) ? 0 : pc+1. Mod-2^ADDR_W arithmetic is not used, so the return address mirrors the PC wrap.
  - If the stack is full (overflow): l=0, no push, stk_err set to 1 at posedge. Execution falls through.
- RET:
  - If stk_cnt>0: l=1, dataIM=top entry; at posedge pop and stk_cnt-=1.
  - If stk_cnt==0 (underflow): l=0, no pop, stk_err set to 1.
- All other opcodes: l=0, stack unchanged.
- A literal greater than PC_LAST is passed through unchanged. The PC's own wrap check handles it; it is not an error here.
- stk_err is sticky and clears only on rst.
- Reset asserted in the same cycle as CALL/RET: reset wins, with no push or pop.
- Flags are sampled in the same cycle as the instruction. The flag register is owned externally.

Decomposition:
- Shared package `isa_pkg`:
  - opcode localparams OP_JMP=7'h4D, OP_JEQ=7'h4E, OP_JNE=7'h4F, OP_JGT=7'h50, OP_JLT=7'h51, OP_JGE=7'h52, OP_JLE=7'h53, OP_JCR=7'h54, OP_JOV=7'h55, OP_CALL=7'h56, OP_RET=7'h57
  - ADDR_W and INSTR_W constants
- Sub-module `ret_stack`:
  - LIFO with ports push, pop, din, top, cnt, full, empty.
  - Synchronous reset.
  - Simultaneous push and pop are disallowed by construction.
- jump_ctrl instantiates `ret_stack` plus the decode logic.

Test Plan:
- Reset, then JMP lit=0x20 at pc=5 -> same cycle l=1, dataIM=0x20; after reset stk_cnt=0, stk_err=0.
- JEQ 0x10 with Z=0, then Z=1 -> l=0/dataIM=0, then l=1/dataIM=0x10. Repeat for JGT with (Z,N)=(0,0) taken and (0,1) not taken.
- CALL 0x40 at pc=12, then RET -> CALL gives l=1, dataIM=0x40, stk_cnt=1; RET gives l=1, dataIM=13, stk_cnt=0.
- CALL at pc=91 (PC_LAST) then RET -> RET drives dataIM=0, not 92.
- Five CALLs without RET -> first four taken, stk_cnt=4; fifth gives l=0, stk_err=1 next cycle. Then RET at stk_cnt=0 after draining -> l=0, stk_err remains 1.
- rst=1 on a CALL cycle with stk_cnt=2 -> l=0, dataIM=0; next cycle stk_cnt=0, stk_err=0.
